tone_arbiter: RTL
=================

# tone_arbiter

Arbiter and note scheduler that shares the single tone-generator input `music_tone` among three note sources: alarm (ch0), UART live play (ch1) and stored-song sequencer (ch2). It accepts one note at a time from the highest-priority requester and holds the tone for the requested number of milliseconds. It then inserts a silent gap and reports completion to the owning requester. Alarm notes preempt the other two sources.

## Interface
- `CLK_PER_MS`, default 50_000: sys_clk cycles per 1 ms tick (50 MHz).
- `GAP_MS`, default 10: silent ms inserted after each note. 0 means no gap.
- `sys_clk`, input, 1: system clock.
- `sys_rst_n`, input, 1: reset sys_rst_n, asynchronous, active-low; clock sys_clk.
- `pause`, input, 1: active-high. Freezes timing and forces silence.
- `vld`, input, 3: per-channel note request. Bit 0 is highest priority.
- `tone0`/`tone1`/`tone2`, input, 8 each: tone code per channel. Code 0 is silence.
- `dur0`/`dur1`/`dur2`, input, 16 each: note duration in ms per channel.
- `rdy`, output, 3: one-cycle accept pulse per channel.
- `done`, output, 3: one-cycle pulse when the channel's note completes normally.
- `aborted`, output, 3: one-cycle pulse when the channel's note is preempted.
- `music_tone`, output, 8: tone code to the tone generator.
- `busy`, output, 1: high in PLAY or GAP.
- `owner`, output, 2: channel currently playing. 2'd3 means none.

## Operation
- States:
  - IDLE: `music_tone` = 0, owner = 3.
  - PLAY: `music_tone` = latched tone.
  - GAP: `music_tone` = 0, owner retained.
- Request handshake:
  - A requester holds `vld[i]` and keeps `tone`/`dur` stable until it sees `rdy[i]`.
  - It deasserts `vld[i]` or presents the next note in the cycle after `rdy[i]`.
- IDLE → PLAY:
  - Trigger: any `vld` bit set and `pause` = 0.
  - The winner is the lowest-index set bit.
  - The accepting edge latches tone and dur, raises `rdy[winner]`, sets owner and `busy`, and restarts the ms prescaler and ms counter.
- Duration rule:
  - dur = 0 is treated as 1.
  - PLAY ends on the tick where ms_cnt == dur−1.
  - That edge pulses `done[owner]`.
  - It then goes to GAP, or to IDLE if GAP_MS = 0.
- GAP → IDLE:
  - Occurs on the tick where ms_cnt == GAP_MS−1.
  - owner → 3, `busy` → 0.
  - A new request is accepted no earlier than the next cycle.
- Preemption:
  - Trigger: state is PLAY or GAP, owner ≠ 0, `vld[0]` = 1, `pause` = 0.
  - On the next edge, ch0 is accepted exactly as from IDLE.
  - If the state was PLAY, `aborted[old owner]` pulses and no `done` is issued for that note.
  - Preempting a GAP produces no pulse.
  - ch1 never preempts ch2.
- Simultaneous PLAY-end and preemption:
  - `done[owner]` pulses and the ch0 accept happens on the same edge, directly into PLAY.
  - No `aborted` pulse.
- Pause:
  - While `pause` = 1, the prescaler, ms counter and state are frozen.
  - `music_tone` = 0, `rdy`/`done`/`aborted` stay 0, and no arbitration occurs.
  - On release, the latched tone resumes for the remaining duration.
- Widths:
  - ms counter is 16 bits and never wraps, because its maximum is 65534.
  - Prescaler width is $clog2(CLK_PER_MS).

## Timing
- Reset values: `music_tone` = 0, `rdy` = `done` = `aborted` = 0, `busy` = 0, owner = 3, state IDLE, all counters 0.
- Reset mid-note silences `music_tone` immediately (asynchronous). No `done` or `aborted` pulse is issued.
- All outputs are registered.
- Accept latency: `vld` sampled high at edge k gives `rdy`, `music_tone`, owner and `busy` valid after edge k.
- Note length is exactly max(dur,1)·CLK_PER_MS unpaused cycles from the accept edge to the edge that pulses `done`.
- The gap is exactly GAP_MS·CLK_PER_MS unpaused cycles.
- Pulses `rdy`, `done` and `aborted` are exactly one cycle wide.
- At most one `rdy` bit is set per cycle.

## Structure
- Package `tone_pkg`:
  - channel index constants CH_ALARM = 0, CH_UART = 1, CH_SONG = 2.
  - OWNER_NONE = 2'd3.
  - TONE_SILENT = 8'd0.
  - state enum {IDLE, PLAY, GAP}.
- Sub-module `ms_tick`: parameterised prescaler with inputs `clr` and `hold` and a one-cycle `tick` output.
- Arbitration, counters and the FSM live in `tone_arbiter`.

## Test plan
Sim parameters: CLK_PER_MS = 10, GAP_MS = 2.
- Reset: assert `sys_rst_n` = 0 mid-simulation → all outputs at reset values in the same cycle, and owner = 3.
- Single ch2 note, tone 6, dur 3:
  - `rdy[2]` pulse at the accept edge.
  - `music_tone` = 6 for 30 cycles, then `done[2]` pulse.
  - `music_tone` = 0 and owner = 2 for 20 cycles, then `busy` = 0.
- `vld[1]` (tone 9, dur 1) and `vld[2]` (tone 6, dur 1) asserted together:
  - ch1 plays for 10 cycles, then the 20-cycle gap.
  - `rdy[2]` one cycle after returning to IDLE.
- Preemption: ch2 plays tone 6 for dur 100; after 50 cycles `vld[0]` is raised with tone 22, dur 2:
  - `aborted[2]` and `rdy[0]` pulse on the same edge.
  - `music_tone` = 22 for 20 cycles, then `done[0]`.
  - `done[2]` never pulses.
- `pause` high for 15 cycles in the middle of a ch1 dur-3 note:
  - `music_tone` = 0 while paused.
  - `done[1]` arrives 45 cycles after accept.
- ch2 with dur 0: plays for 10 cycles, then `done[2]`.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared constants, FSM state type and channel helpers for the tone arbiter.
package tone_pkg;

    localparam logic [1:0] CH_ALARM    = 2'd0;
    localparam logic [1:0] CH_UART     = 2'd1;
    localparam logic [1:0] CH_SONG     = 2'd2;
    localparam logic [1:0] OWNER_NONE  = 2'd3;
    localparam logic [7:0] TONE_SILENT = 8'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_e;

    // Lowest-index requester wins; OWNER_NONE when nobody asks.
    function automatic logic [1:0] pick_winner(input logic [2:0] req);
        if (req[0]) begin
            return CH_ALARM;
        end else if (req[1]) begin
            return CH_UART;
        end else if (req[2]) begin
            return CH_SONG;
        end else begin
            return OWNER_NONE;
        end
    endfunction

    function automatic logic [2:0] chan_onehot(input logic [1:0] ch);
        case (ch)
            CH_ALARM: return 3'b001;
            CH_UART:  return 3'b010;
            CH_SONG:  return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/tone_arbiter_ms_tick.sv
// Millisecond prescaler: tick is high while the count sits on its last value,
// so the consumer acts on the edge that wraps the count.
module ms_tick #(
    parameter int CLK_PER_MS = 50_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int            PW   = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_PER_MS - 1);

    logic [PW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Next prescaler count and its registered wrap flag.
    always_comb begin
        if (clr) begin
            cnt_d = {PW{1'b0}};
        end else if (hold) begin
            cnt_d = cnt_q;
        end else if (cnt_q == LAST) begin
            cnt_d = {PW{1'b0}};
        end else begin
            cnt_d = cnt_q + PW'(1);
        end
        tick_d = (cnt_d == LAST);
    end

    // Prescaler state registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q  <= {PW{1'b0}};
            tick_q <= (LAST == {PW{1'b0}});
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/tone_arbiter.sv
// Shares one tone-generator input among alarm, UART and song sources with
// ms-timed notes, a silent gap after each note, and alarm preemption.
module tone_arbiter
    import tone_pkg::*;
#(
    parameter int CLK_PER_MS = 50_000,
    parameter int GAP_MS     = 10
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        pause,
    input  logic [2:0]  vld,
    input  logic [7:0]  tone0,
    input  logic [7:0]  tone1,
    input  logic [7:0]  tone2,
    input  logic [15:0] dur0,
    input  logic [15:0] dur1,
    input  logic [15:0] dur2,
    output logic [2:0]  rdy,
    output logic [2:0]  done,
    output logic [2:0]  aborted,
    output logic [7:0]  music_tone,
    output logic        busy,
    output logic [1:0]  owner
);

    localparam logic [15:0] GAP_M1 = 16'(GAP_MS - 1);

    state_e      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [7:0]  tone_q, tone_d;
    logic [15:0] dur_m1_q, dur_m1_d;
    logic [15:0] ms_cnt_q, ms_cnt_d;
    logic [2:0]  rdy_q, rdy_d, done_q, done_d, aborted_q, aborted_d;
    logic [7:0]  music_tone_q, music_tone_d;
    logic        busy_q, busy_d;

    logic        tick, clr, accept;
    logic [1:0]  winner;
    logic [7:0]  sel_tone;
    logic [15:0] sel_dur;

    ms_tick #(.CLK_PER_MS(CLK_PER_MS)) u_ms_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (clr),
        .hold      (pause),
        .tick      (tick)
    );

    // Winner selection and the note it would latch.
    always_comb begin
        winner = pick_winner(vld);
        case (winner)
            CH_ALARM: begin sel_tone = tone0;       sel_dur = dur0;  end
            CH_UART:  begin sel_tone = tone1;       sel_dur = dur1;  end
            CH_SONG:  begin sel_tone = tone2;       sel_dur = dur2;  end
            default:  begin sel_tone = TONE_SILENT; sel_dur = 16'd0; end
        endcase
    end

    // Scheduler FSM next-state, counters and output pulses.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        tone_d    = tone_q;
        dur_m1_d  = dur_m1_q;
        ms_cnt_d  = ms_cnt_q;
        rdy_d     = 3'b000;
        done_d    = 3'b000;
        aborted_d = 3'b000;
        accept    = 1'b0;
        clr       = 1'b0;
        if (!pause) begin
            case (state_q)
                IDLE: begin
                    accept = |vld;
                end
                PLAY: begin
                    if (tick) begin
                        if (ms_cnt_q == dur_m1_q) begin
                            done_d   = chan_onehot(owner_q);
                            ms_cnt_d = 16'd0;
                            if (GAP_MS == 0) begin
                                state_d = IDLE;
                                owner_d = OWNER_NONE;
                            end else begin
                                state_d = GAP;
                            end
                        end else begin
                            ms_cnt_d = ms_cnt_q + 16'd1;
                        end
                    end else begin
                        ms_cnt_d = ms_cnt_q;
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (ms_cnt_q == GAP_M1) begin
                            state_d  = IDLE;
                            owner_d  = OWNER_NONE;
                            ms_cnt_d = 16'd0;
                        end else begin
                            ms_cnt_d = ms_cnt_q + 16'd1;
                        end
                    end else begin
                        ms_cnt_d = ms_cnt_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    owner_d = OWNER_NONE;
                end
            endcase
            // An alarm cuts in; a note that just finished keeps its done instead.
            if ((state_q != IDLE) && (owner_q != CH_ALARM) && vld[0]) begin
                accept = 1'b1;
                if ((state_q == PLAY) && (done_d == 3'b000)) begin
                    aborted_d = chan_onehot(owner_q);
                end else begin
                    aborted_d = 3'b000;
                end
            end else begin
                aborted_d = 3'b000;
            end
            if (accept) begin
                state_d  = PLAY;
                owner_d  = winner;
                tone_d   = sel_tone;
                dur_m1_d = (sel_dur == 16'd0) ? 16'd0 : (sel_dur - 16'd1);
                ms_cnt_d = 16'd0;
                rdy_d    = chan_onehot(winner);
                clr      = 1'b1;
            end else begin
                clr      = 1'b0;
            end
        end else begin
            accept = 1'b0;
        end
        music_tone_d = (!pause && (state_d == PLAY)) ? tone_d : TONE_SILENT;
        busy_d       = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_NONE;
            tone_q       <= TONE_SILENT;
            dur_m1_q     <= 16'd0;
            ms_cnt_q     <= 16'd0;
            rdy_q        <= 3'b000;
            done_q       <= 3'b000;
            aborted_q    <= 3'b000;
            music_tone_q <= TONE_SILENT;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            tone_q       <= tone_d;
            dur_m1_q     <= dur_m1_d;
            ms_cnt_q     <= ms_cnt_d;
            rdy_q        <= rdy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            music_tone_q <= music_tone_d;
            busy_q       <= busy_d;
        end
    end

    assign rdy        = rdy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign music_tone = music_tone_q;
    assign busy       = busy_q;
    assign owner      = owner_q;

endmodule
